// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: default widths and
// the requester index encoding used by the grant history.
package mem_arbiter_pkg;

  localparam int MEM_WIDTH_DEF  = 8;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone eligible requester wins, and on a conflict
// the requester that was not granted last wins.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  output logic [1:0] gnt
);

  req_idx_t last_grant;

  always_comb begin
    gnt = 2'b00;
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == REQ1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to REQ1 so that requester 0 takes the first conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ1;
    end else if (|gnt) begin
      last_grant <= gnt[1] ? REQ1 : REQ0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between two requesters, one access
// per cycle, with a one-entry read response buffer per requester.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [MEM_WIDTH-1:0]  req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [MEM_WIDTH-1:0]  req1_wdata,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [MEM_WIDTH-1:0]  rsp0_rdata,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [MEM_WIDTH-1:0]  rsp1_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_din,
  input  logic [MEM_WIDTH-1:0]  mem_dout,
  output logic [1:0]            grant_leds
);

  logic [1:0]            req_valid;
  logic [1:0]            req_we;
  logic [1:0]            rsp_ready;
  logic [1:0]            elig;
  logic [1:0]            gnt;
  logic [1:0]            rd_pend;
  logic [1:0]            rsp_valid;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [MEM_WIDTH-1:0]  din_q;

  assign req_valid = {req1_valid, req0_valid};
  assign req_we    = {req1_we, req0_we};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A read waits while its own previous read is in flight or still buffered;
  // nothing is eligible during reset so no access reaches the memory.
  assign elig = {2{~rst}} & req_valid & (req_we | ~(rd_pend | rsp_valid));

  rr_arbiter2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .elig (elig),
    .gnt  (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = addr_q;
    mem_din  = din_q;
    if (rst) begin
      mem_addr = '0;
      mem_din  = '0;
    end else if (gnt[0]) begin
      mem_we   = req0_we;
      mem_addr = req0_addr;
      mem_din  = req0_wdata;
    end else if (gnt[1]) begin
      mem_we   = req1_we;
      mem_addr = req1_addr;
      mem_din  = req1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      din_q      <= '0;
      grant_leds <= 2'b00;
    end else if (|gnt) begin
      addr_q     <= mem_addr;
      din_q      <= mem_din;
      grant_leds <= gnt;
    end
  end

  // Read stage boundary: handshake cycle -> pending -> data captured from memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend   <= 2'b00;
      rsp_valid <= 2'b00;
    end else begin
      rd_pend   <= gnt & ~req_we;
      rsp_valid <= rd_pend | (rsp_valid & ~rsp_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      if (rd_pend[0]) rsp0_rdata <= mem_dout;
      if (rd_pend[1]) rsp1_rdata <= mem_dout;
    end
  end

endmodule
